// File: rtl/line_fetch_ctrl_pkg.sv
// Shared constants, FSM state codes and address helper for the line fetch controller.
// Blanking of off-frame columns is enabled with the LINE_FETCH_BLANK_EN macro.
package line_fetch_ctrl_pkg;

    localparam int BYTES_PER_PIXEL   = 4;
    localparam int DEF_LINE_PIXELS   = 1024;
    localparam int DEF_ACTIVE_PIXELS = 640;
    localparam int DEF_BURST_WORDS   = 16;
    localparam int COL_W             = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } lf_state_e;

    // Byte address of the first fetched pixel; wraps modulo 2^32 in both directions.
    function automatic logic [31:0] line_start_addr(input logic [31:0]      base,
                                                    input logic [COL_W-1:0] off,
                                                    input logic             dir);
        logic [31:0] delta;
        delta = 32'(off) << $clog2(BYTES_PER_PIXEL);
        return dir ? (base - delta) : (base + delta);
    endfunction

endpackage

// File: rtl/line_fetch_col_mask.sv
// Flags a column as off-frame from the latched horizontal offset and direction.
// Only compiled in when LINE_FETCH_BLANK_EN is defined.
`ifdef LINE_FETCH_BLANK_EN
module line_fetch_col_mask
    import line_fetch_ctrl_pkg::*;
#(
    parameter int ACTIVE_PIXELS = DEF_ACTIVE_PIXELS
) (
    input  logic [COL_W-1:0] i_col,
    input  logic [COL_W-1:0] i_off,
    input  logic             i_dir,
    output logic             o_blank
);

    logic [COL_W:0] src_col;

    always_comb begin
        src_col = {1'b0, i_col} + {1'b0, i_off};
        o_blank = (i_col >= COL_W'(ACTIVE_PIXELS));
        if (i_dir) begin
            o_blank = o_blank | (i_col < i_off);
        end else begin
            o_blank = o_blank | (src_col >= (COL_W+1)'(ACTIVE_PIXELS));
        end
    end

endmodule
`endif

// File: rtl/line_fetch_ctrl.sv
// Fetches one stored line as sequential MPMC bursts and re-emits it as a column-tagged pixel stream.
// Define LINE_FETCH_BLANK_EN to force off-frame source columns to black.
module line_fetch_ctrl
    import line_fetch_ctrl_pkg::*;
#(
    parameter int LINE_PIXELS   = DEF_LINE_PIXELS,
    parameter int ACTIVE_PIXELS = DEF_ACTIVE_PIXELS,
    parameter int BURST_WORDS   = DEF_BURST_WORDS,
    parameter int DATA_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_line_start,
    input  logic [31:0]       i_line_addr,
    input  logic [COL_W-1:0]  i_x_off,
    input  logic              i_x_dir,
    output logic              o_rd_req,
    output logic [31:0]       o_rd_addr,
    input  logic              i_rd_ack,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid,
    output logic [DATA_W-1:0] o_pix_data,
    output logic [COL_W-1:0]  o_pix_col,
    output logic              o_pix_valid,
    output logic              o_busy,
    output logic              o_line_done,
    output logic              o_overrun
);

    localparam int NUM_BURSTS = LINE_PIXELS / BURST_WORDS;
    localparam int BCNT_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WCNT_W     = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    localparam logic [31:0]       BURST_BYTES = 32'(BURST_WORDS * BYTES_PER_PIXEL);
    localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(NUM_BURSTS - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(BURST_WORDS - 1);

    if (LINE_PIXELS % BURST_WORDS != 0) begin : g_bad_burst
        $error("LINE_PIXELS must be a multiple of BURST_WORDS");
    end
    if (ACTIVE_PIXELS > LINE_PIXELS) begin : g_bad_active
        $error("ACTIVE_PIXELS must not exceed LINE_PIXELS");
    end

    lf_state_e         state_q, state_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [COL_W-1:0]  pix_col_q, pix_col_d;
    logic              pix_valid_q, pix_valid_d;
    logic              line_done_q, line_done_d;
    logic              overrun_q, overrun_d;
    logic              blank;

`ifdef LINE_FETCH_BLANK_EN
    logic [COL_W-1:0]  off_q, off_d;
    logic              dir_q, dir_d;

    line_fetch_col_mask #(
        .ACTIVE_PIXELS (ACTIVE_PIXELS)
    ) u_col_mask (
        .i_col   (col_q),
        .i_off   (off_q),
        .i_dir   (dir_q),
        .o_blank (blank)
    );
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        burst_cnt_d = burst_cnt_q;
        word_cnt_d  = word_cnt_q;
        col_d       = col_q;
        pix_data_d  = pix_data_q;
        pix_col_d   = pix_col_q;
        pix_valid_d = 1'b0;
        line_done_d = 1'b0;
        overrun_d   = overrun_q;
`ifdef LINE_FETCH_BLANK_EN
        off_d       = off_q;
        dir_d       = dir_q;
`endif

        // A start pulse is only accepted in IDLE; anywhere else it is flagged.
        if (i_line_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_line_start) begin
                    state_d     = ST_REQ;
                    rd_addr_d   = line_start_addr(i_line_addr, i_x_off, i_x_dir);
                    burst_cnt_d = '0;
                    word_cnt_d  = '0;
                    col_d       = '0;
`ifdef LINE_FETCH_BLANK_EN
                    off_d       = i_x_off;
                    dir_d       = i_x_dir;
`endif
                end
            end
            ST_REQ: begin
                if (i_rd_ack) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_rd_valid) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = blank ? '0 : i_rd_data;
                    pix_col_d   = col_q;
                    col_d       = col_q + 1'b1;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        if (burst_cnt_q == LAST_BURST) begin
                            state_d = ST_DONE;
                        end else begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                            rd_addr_d   = rd_addr_q + BURST_BYTES;
                            state_d     = ST_REQ;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                line_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            burst_cnt_q <= '0;
            word_cnt_q  <= '0;
            col_q       <= '0;
            pix_data_q  <= '0;
            pix_col_q   <= '0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            burst_cnt_q <= burst_cnt_d;
            word_cnt_q  <= word_cnt_d;
            col_q       <= col_d;
            pix_data_q  <= pix_data_d;
            pix_col_q   <= pix_col_d;
            pix_valid_q <= pix_valid_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef LINE_FETCH_BLANK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            off_q <= '0;
            dir_q <= 1'b0;
        end else begin
            off_q <= off_d;
            dir_q <= dir_d;
        end
    end
`endif

    assign o_rd_req    = (state_q == ST_REQ);
    assign o_rd_addr   = rd_addr_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_pix_data  = pix_data_q;
    assign o_pix_col   = pix_col_q;
    assign o_pix_valid = pix_valid_q;
    assign o_line_done = line_done_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench for line_fetch_ctrl: table of whole-line fetches plus overrun and reset sequences.
module tb_line_fetch_ctrl;

    localparam int LP = 1024;
    localparam int AP = 640;
    localparam int BW = 16;
`ifdef LINE_FETCH_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [31:0] line_addr;
    logic [10:0] x_off;
    logic        x_dir;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] pix_data;
    logic [10:0] pix_col;
    logic        pix_valid;
    logic        busy;
    logic        line_done;
    logic        overrun;

    always #5 clk = ~clk;

    line_fetch_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_line_start (line_start),
        .i_line_addr  (line_addr),
        .i_x_off      (x_off),
        .i_x_dir      (x_dir),
        .o_rd_req     (rd_req),
        .o_rd_addr    (rd_addr),
        .i_rd_ack     (rd_ack),
        .i_rd_data    (rd_data),
        .i_rd_valid   (rd_valid),
        .o_pix_data   (pix_data),
        .o_pix_col    (pix_col),
        .o_pix_valid  (pix_valid),
        .o_busy       (busy),
        .o_line_done  (line_done),
        .o_overrun    (overrun)
    );

    typedef struct {
        logic [31:0] addr;
        logic [10:0] off;
        logic        dir;
        int          ack_dly;
        int          gap;
        logic [31:0] exp_first;
        int          exp_blank;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad   = 0;

    logic [31:0] cur_a   = 32'h0;
    logic [10:0] cur_off = 11'd0;
    logic        cur_dir = 1'b0;
    int          ack_dly = 0;
    int          gap     = 0;

    int          req_cnt = 0, req_addr_err = 0, addr_unstable = 0;
    int          pix_cnt = 0, pix_err = 0, zero_cnt = 0;
    int          done_cnt = 0, done_timing_err = 0;
    int          pix_total = 0, req_total = 0;
    logic [31:0] first_req_addr = 32'h0;
    logic        prev_req = 1'b0, prev_pv = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [10:0] prev_col = 11'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
    endfunction

    function automatic bit off_frame(input int c, input int off, input logic dir);
        if (c >= AP) return 1'b1;
        if (dir) return (c < off);
        return (c + off >= AP);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // memory responder: acks after ack_dly cycles, returns BW words with gap idle cycles between
    initial begin : responder
        logic [31:0] baddr;
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rd_req) begin
                repeat (ack_dly) begin @(posedge clk); #1; end
                rd_ack = 1'b1;
                baddr  = rd_addr;
                @(posedge clk); #1;
                rd_ack = 1'b0;
                for (int w = 0; w < BW; w++) begin
                    repeat (gap) begin @(posedge clk); #1; end
                    rd_valid = 1'b1;
                    rd_data  = mem_word(baddr + 32'(4 * w));
                    @(posedge clk); #1;
                    rd_valid = 1'b0;
                end
            end
        end
    end

    // scoreboard sampled on the falling edge
    always @(negedge clk) begin
        logic [31:0] exp;
        if (line_start && !busy && !rst) begin
            req_cnt = 0; req_addr_err = 0; addr_unstable = 0;
            pix_cnt = 0; pix_err = 0; zero_cnt = 0;
            done_cnt = 0; done_timing_err = 0;
        end
        if (rd_req && !prev_req) begin
            if (req_cnt == 0) first_req_addr = rd_addr;
            if (rd_addr !== cur_a + 32'(req_cnt * 4 * BW)) req_addr_err++;
            req_cnt++;
            req_total++;
        end
        if (rd_req && prev_req && (rd_addr !== prev_addr)) addr_unstable++;
        if (pix_valid) begin
            exp = (BLANK && off_frame(pix_cnt, int'(cur_off), cur_dir)) ? 32'h0
                  : mem_word(cur_a + 32'(4 * pix_cnt));
            if ((pix_col !== 11'(pix_cnt)) || (pix_data !== exp)) pix_err++;
            if (pix_data == 32'h0) zero_cnt++;
            pix_cnt++;
            pix_total++;
        end
        if (line_done) begin
            done_cnt++;
            if (!(prev_pv && (prev_col == 11'd1023))) done_timing_err++;
        end
        prev_req  = rd_req;
        prev_addr = rd_addr;
        prev_pv   = pix_valid;
        prev_col  = pix_col;
    end

    // mode 0: clean line; 1: extra start pulse mid-line; 2: extra start pulse in DONE
    task automatic run_line(input vec_t v, input int mode);
        bit seen;
        cur_a   = v.exp_first;
        cur_off = v.off;
        cur_dir = v.dir;
        ack_dly = v.ack_dly;
        gap     = v.gap;
        @(posedge clk); #1;
        line_addr  = v.addr;
        x_off      = v.off;
        x_dir      = v.dir;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        check("start_latency_req_busy", {30'd0, rd_req, busy}, 32'd3);
        line_addr = 32'hDEAD_BEEF;
        x_off     = 11'h7FF;
        x_dir     = ~v.dir;
        if (mode == 1) begin
            seen = 1'b0;
            for (int c = 0; c < 5000 && !seen; c++) begin
                @(posedge clk); #1;
                seen = (req_cnt >= 5);
            end
            check("midline_wait", {31'd0, seen}, 32'd1);
            line_addr  = 32'h9000;
            x_off      = 11'd3;
            line_start = 1'b1;
            @(posedge clk); #1;
            line_start = 1'b0;
        end else if (mode == 2) begin
            seen = 1'b0;
            for (int c = 0; c < 20000 && !seen; c++) begin
                @(negedge clk);
                seen = pix_valid && (pix_col == 11'd1023);
            end
            check("last_pixel_wait", {31'd0, seen}, 32'd1);
            line_addr  = 32'h9000;
            line_start = 1'b1;
            @(posedge clk); #1;
            line_start = 1'b0;
        end
        for (int c = 0; c < 20000 && done_cnt == 0; c++) @(posedge clk);
        check("line_done_timeout", {31'd0, done_cnt > 0}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("first_req_addr", first_req_addr, v.exp_first);
        check("req_count", req_cnt, LP / BW);
        check("req_addr_seq_errs", req_addr_err, 0);
        check("req_addr_unstable", addr_unstable, 0);
        check("pixel_count", pix_cnt, LP);
        check("pixel_errs", pix_err, 0);
        check("zero_pixels", zero_cnt, BLANK ? v.exp_blank : 0);
        check("line_done_pulses", done_cnt, 1);
        check("line_done_timing_errs", done_timing_err, 0);
        check("idle_after_line", {30'd0, busy, rd_req}, 0);
    endtask

    initial begin
        int snap_pix;
        int snap_req;
        bit seen;
        vecs[0] = '{32'h0000_1000, 11'd0,   1'b0, 0, 0, 32'h0000_1000, 384};
        vecs[1] = '{32'h0000_1000, 11'd8,   1'b0, 0, 0, 32'h0000_1020, 392};
        vecs[2] = '{32'h0000_1000, 11'd8,   1'b1, 0, 0, 32'h0000_0FE0, 392};
        vecs[3] = '{32'h0000_2000, 11'd0,   1'b0, 5, 3, 32'h0000_2000, 384};
        vecs[4] = '{32'h0000_0010, 11'd100, 1'b1, 1, 1, 32'hFFFF_FE80, 484};
        vecs[5] = '{32'h0000_4000, 11'd700, 1'b0, 2, 0, 32'h0000_4AF0, 1024};

        rst        = 1'b1;
        line_start = 1'b0;
        line_addr  = 32'h0;
        x_off      = 11'd0;
        x_dir      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outputs", {27'd0, rd_req, busy, pix_valid, line_done, overrun}, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_pix_data", pix_data, 0);
        check("reset_pix_col", {21'd0, pix_col}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_req", {30'd0, rd_req, busy}, 0);

        for (int i = 0; i < 6; i++) run_line(vecs[i], 0);
        check("no_overrun_clean_lines", {31'd0, overrun}, 0);

        run_line(vecs[0], 1);
        check("overrun_midline", {31'd0, overrun}, 1);
        repeat (10) @(posedge clk);
        #1;
        check("overrun_sticky", {31'd0, overrun}, 1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("overrun_cleared_by_reset", {31'd0, overrun}, 0);

        run_line(vecs[1], 2);
        check("overrun_start_in_done", {31'd0, overrun}, 1);
        repeat (5) @(posedge clk);
        #1;
        check("done_start_not_accepted", {30'd0, busy, rd_req}, 0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur_a   = 32'h0000_3000;
        cur_off = 11'd0;
        cur_dir = 1'b0;
        ack_dly = 0;
        gap     = 1;
        line_addr  = 32'h0000_3000;
        x_off      = 11'd0;
        x_dir      = 1'b0;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(posedge clk); #1;
            seen = (req_cnt >= 11);
        end
        check("burst10_wait", {31'd0, seen}, 1);
        check("pixels_before_reset", pix_cnt, 10 * BW);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_busy_pix", {29'd0, rd_req, busy, pix_valid}, 0);
        snap_pix = pix_total;
        snap_req = req_total;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_trailing_pixels", pix_total - snap_pix, 0);
        check("abort_no_new_requests", req_total - snap_req, 0);
        check("abort_idle", {30'd0, busy, line_done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
